pal_sync_sequencer: RTL and testbench
=====================================

# pal_sync_sequencer

Timing controller that sequences the RF video emitter. It produces the composite sync and gated monochrome video bits for a 312-line progressive PAL-style raster, and exposes the raster position to an upstream pixel source. It runs on the 200 MHz carrier clock, advanced by a pixel clock-enable, and feeds the emitter's `csync` and `video` inputs directly.

## Interface
- `H_TOTAL`, 512: ce ticks per 64 µs line (8 MHz ce).
- `HSYNC_LEN`, 38: normal line sync low length (4.7 µs).
- `EQ_LEN`, 19: equalising pulse low length (2.35 µs).
- `BROAD_LEN`, 218: broad (vsync) pulse low length (27.3 µs).
- `ACT_START`, 96: first active tick in a line.
- `ACT_LEN`, 416: active ticks per line.
- `V_TOTAL`, 312: lines per frame.
- `V_ACT_START`, 40: first active line.
- `V_ACT_LEN`, 256: active lines.
- `clkp` input 1: 200 MHz master clock.
- `rst` input 1: asynchronous, active-high reset.
- `ce` input 1: pixel tick; state advances only on `clkp` edges with `ce`=1.
- `en` input 1: run enable.
- `pix_in` input 1: pixel for current `hpos`/`vpos`; 1 = white.
- `hpos` output 10: horizontal counter, 0..H_TOTAL-1.
- `vpos` output 9: line counter, 0..V_TOTAL-1.
- `active` output 1: combinational; current position is inside the active window.
- `csync` output 1: registered composite sync, 0 = sync tip.
- `video` output 1: registered video bit, 0 = black.
- `line_start` output 1: one-`clkp` pulse when `hpos` wraps to 0.
- `frame_start` output 1: one-`clkp` pulse when (`hpos`,`vpos`) wraps to (0,0).

## Operation
- Reset values: `hpos`=0, `vpos`=0, `csync`=1, `video`=0, `line_start`=0, `frame_start`=0.
- Counter advance, on `ce`=1 with `en`=1:
  - `hpos` increments.
  - At H_TOTAL-1, `hpos` wraps to 0 and `vpos` increments.
  - At V_TOTAL-1, `vpos` wraps to 0.
- Line class is decoded from `vpos` (half-line point H = H_TOTAL/2 = 256):
  - BROAD, lines 0..2: sync low for h<BROAD_LEN, or H≤h<H+BROAD_LEN. This gives 6 broad pulses.
  - POST_EQ, lines 3..4: sync low for h<EQ_LEN, or H≤h<H+EQ_LEN.
  - PRE_EQ, lines V_TOTAL-2..V_TOTAL-1: same pattern as POST_EQ.
  - NORMAL, all other lines: sync low for h<HSYNC_LEN.
- `active` = (ACT_START ≤ hpos < ACT_START+ACT_LEN) AND (V_ACT_START ≤ vpos < V_ACT_START+V_ACT_LEN).
- `video` register loads `pix_in & active & sync_high`. Video is never 1 during a sync-low tick or outside the active window.
- `csync` register loads the decoded sync level for the current position.
- Disable behaviour:
  - `en`=0 (sampled every `clkp` edge, ce-independent): next edge forces `hpos`=0, `vpos`=0, `csync`=1, `video`=0, and no pulses.
  - On `en` rising, the first ce edge processes position (0,0). No partial frame is resumed.
- Parameter constraints: ACT_START+ACT_LEN ≤ H_TOTAL, HSYNC_LEN < ACT_START, BROAD_LEN < H, V_ACT_START ≥ 5, V_ACT_START+V_ACT_LEN ≤ V_TOTAL-2.

## Timing
- `csync`/`video` lag `hpos`/`vpos` by exactly one ce tick.
  - On the ce edge where the counters move from p to p+1, the outputs take the value decoded from p.
- `pix_in` is sampled on the ce edge at which `hpos`/`vpos` show the pixel's position. The pixel source therefore has one ce period (25 `clkp`) to respond combinationally or with registered logic.
- `line_start`/`frame_start` assert for exactly one `clkp` cycle, following the ce edge that wrapped the counter(s). They never assert with `en`=0.
- Between ce ticks all outputs hold.
- Asynchronous `rst` mid-line returns every output to its reset value immediately. The first ce after release processes (0,0).
- Frame length: H_TOTAL × V_TOTAL = 159744 ce ticks.

## Test plan
- Reset, `en`=1, `ce` every cycle, run 512 ticks on line 10 → `csync` low for exactly 38 ticks starting one tick after `hpos`=0; `video`=0 throughout (line not active).
- Lines 0..2 → six `csync` low pulses of 218 ticks at h offsets 0 and 256. Lines 3..4 and 310..311 → 19-tick pulses at offsets 0 and 256.
- `pix_in`=1 constant → `video`=1 exactly for hpos 96..511 on lines 40..295, delayed one tick. Count = 416×256 = 106496 ticks per frame.
- Run 2 frames → `frame_start` pulses exactly 159744 ce ticks apart, one `clkp` wide. `line_start` counts 312 per frame.
- `ce` asserted 1-in-25 → counters and outputs change only on ce edges. `frame_start` period = 159744×25 `clkp`.
- Drop `en` at line 100, h 200; re-raise after 7 cycles → `csync`=1 and `video`=0 while low. Restart at (0,0), with first `csync` low on the following tick. Assert `rst` mid-broad pulse → `csync`=1 asynchronously.

Source files
------------

// File: rtl/pal_sync_sequencer.sv
// rtl/pal_sync_sequencer.sv - raster timing, composite sync and gated video for a progressive PAL-style frame
//
// Purpose: walks an H_TOTAL x V_TOTAL raster on pixel clock-enable ticks of the
// carrier clock, decodes the composite sync pattern for each position (broad,
// equalising or normal line sync), gates the upstream pixel into the active
// window and registers both towards the RF emitter.
//
// Ports:
//   clkp        200 MHz carrier clock
//   rst         asynchronous active-high reset
//   ce          pixel tick; counters and outputs move only on clkp edges with ce=1
//   en          run enable; low forces the raster back to (0,0) on the next clkp edge
//   pix_in      pixel for the position currently shown on hpos/vpos (1 = white)
//   hpos        horizontal position 0..H_TOTAL-1
//   vpos        line number 0..V_TOTAL-1
//   active      combinational, current position lies inside the active window
//   csync       registered composite sync, 0 = sync tip
//   video       registered video bit, 0 = black
//   line_start  one-clkp pulse after the tick that wrapped hpos to 0
//   frame_start one-clkp pulse after the tick that wrapped (hpos,vpos) to (0,0)

module pal_sync_sequencer #(
    parameter int H_TOTAL     = 512,
    parameter int HSYNC_LEN   = 38,
    parameter int EQ_LEN      = 19,
    parameter int BROAD_LEN   = 218,
    parameter int ACT_START   = 96,
    parameter int ACT_LEN     = 416,
    parameter int V_TOTAL     = 312,
    parameter int V_ACT_START = 40,
    parameter int V_ACT_LEN   = 256
) (
    input  logic       clkp,
    input  logic       rst,
    input  logic       ce,
    input  logic       en,
    input  logic       pix_in,
    output logic [9:0] hpos,
    output logic [8:0] vpos,
    output logic       active,
    output logic       csync,
    output logic       video,
    output logic       line_start,
    output logic       frame_start
);

    // Thresholds pre-sized to the counter widths so every compare is same-width.
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_HALF       = 10'(H_TOTAL / 2);
    localparam logic [9:0] H_SYNC_END   = 10'(HSYNC_LEN);
    localparam logic [9:0] H_EQ_END     = 10'(EQ_LEN);
    localparam logic [9:0] H_BROAD_END  = 10'(BROAD_LEN);
    localparam logic [9:0] H_HEQ_END    = 10'(H_TOTAL / 2 + EQ_LEN);
    localparam logic [9:0] H_HBROAD_END = 10'(H_TOTAL / 2 + BROAD_LEN);
    localparam logic [9:0] H_ACT_FIRST  = 10'(ACT_START);
    localparam logic [9:0] H_ACT_END    = 10'(ACT_START + ACT_LEN);

    localparam logic [8:0] V_LAST       = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_BROAD_LAST = 9'd2;
    localparam logic [8:0] V_POSTEQ_LAST = 9'd4;
    localparam logic [8:0] V_PREEQ_FIRST = 9'(V_TOTAL - 2);
    localparam logic [8:0] V_ACT_FIRST  = 9'(V_ACT_START);
    localparam logic [8:0] V_ACT_END    = 9'(V_ACT_START + V_ACT_LEN);

    typedef enum logic [1:0] {
        LINE_BROAD  = 2'd0,
        LINE_EQ     = 2'd1,
        LINE_NORMAL = 2'd2
    } line_class_t;

    logic [9:0]  hpos_q, hpos_d;
    logic [8:0]  vpos_q, vpos_d;
    logic        csync_q, csync_d;
    logic        video_q, video_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    line_class_t line_class;
    logic        sync_low;
    logic        h_active;
    logic        v_active;
    logic        pos_active;
    logic        second_half;

    // Pre-equalising lines at the end of the frame share the post-equalising pattern.
    always_comb begin
        line_class = LINE_NORMAL;
        if (vpos_q <= V_BROAD_LAST) begin
            line_class = LINE_BROAD;
        end else if ((vpos_q <= V_POSTEQ_LAST) || (vpos_q >= V_PREEQ_FIRST)) begin
            line_class = LINE_EQ;
        end
    end

    // Broad and equalising lines carry two pulses, one at each half-line point.
    always_comb begin
        second_half = (hpos_q >= H_HALF);
        sync_low    = 1'b0;
        case (line_class)
            LINE_BROAD:  sync_low = (hpos_q < H_BROAD_END) ||
                                    (second_half && (hpos_q < H_HBROAD_END));
            LINE_EQ:     sync_low = (hpos_q < H_EQ_END) ||
                                    (second_half && (hpos_q < H_HEQ_END));
            default:     sync_low = (hpos_q < H_SYNC_END);
        endcase
    end

    always_comb begin
        h_active   = (hpos_q >= H_ACT_FIRST) && (hpos_q < H_ACT_END);
        v_active   = (vpos_q >= V_ACT_FIRST) && (vpos_q < V_ACT_END);
        pos_active = h_active && v_active;
    end

    // Outputs are decoded from the position being left, so csync/video trail
    // the counters by exactly one tick. Pulses default low so they last one clkp.
    always_comb begin
        hpos_d        = hpos_q;
        vpos_d        = vpos_q;
        csync_d       = csync_q;
        video_d       = video_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (!en) begin
            hpos_d  = 10'd0;
            vpos_d  = 9'd0;
            csync_d = 1'b1;
            video_d = 1'b0;
        end else if (ce) begin
            csync_d = ~sync_low;
            video_d = pix_in & pos_active & ~sync_low;
            if (hpos_q == H_LAST) begin
                hpos_d       = 10'd0;
                line_start_d = 1'b1;
                if (vpos_q == V_LAST) begin
                    vpos_d        = 9'd0;
                    frame_start_d = 1'b1;
                end else begin
                    vpos_d = vpos_q + 9'd1;
                end
            end else begin
                hpos_d = hpos_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clkp or posedge rst) begin
        if (rst) begin
            hpos_q        <= 10'd0;
            vpos_q        <= 9'd0;
            csync_q       <= 1'b1;
            video_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            csync_q       <= csync_d;
            video_q       <= video_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign active      = pos_active;
    assign csync       = csync_q;
    assign video       = video_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pal_sync_sequencer.sv
// tb/tb_pal_sync_sequencer.sv - self-checking bench for pal_sync_sequencer

module tb_pal_sync_sequencer;

    // Reduced raster for whole-frame runs; default-parameter instance for full-size line checks.
    localparam int H     = 48;
    localparam int HS    = 4;
    localparam int EQ    = 2;
    localparam int BR    = 15;
    localparam int AS    = 8;
    localparam int AL    = 36;
    localparam int V     = 16;
    localparam int VAS   = 5;
    localparam int VAL   = 8;
    localparam int FRAME = H * V;
    localparam int DFRAME = 512 * 312;
    localparam int DN    = 12 * 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       en = 1'b0;
    logic       en_def = 1'b0;
    logic       pix = 1'b0;
    logic [9:0] hpos;
    logic [8:0] vpos;
    logic       active, csync, video, line_start, frame_start;
    logic [9:0] df_hpos;
    logic [8:0] df_vpos;
    logic       df_active, df_csync, df_video, df_ls, df_fs;

    pal_sync_sequencer #(
        .H_TOTAL(H), .HSYNC_LEN(HS), .EQ_LEN(EQ), .BROAD_LEN(BR),
        .ACT_START(AS), .ACT_LEN(AL), .V_TOTAL(V), .V_ACT_START(VAS), .V_ACT_LEN(VAL)
    ) u_dut (
        .clkp(clk), .rst(rst), .ce(ce), .en(en), .pix_in(pix),
        .hpos(hpos), .vpos(vpos), .active(active), .csync(csync), .video(video),
        .line_start(line_start), .frame_start(frame_start)
    );

    pal_sync_sequencer u_def (
        .clkp(clk), .rst(rst), .ce(1'b1), .en(en_def), .pix_in(1'b1),
        .hpos(df_hpos), .vpos(df_vpos), .active(df_active), .csync(df_csync), .video(df_video),
        .line_start(df_ls), .frame_start(df_fs)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sync level (1 = high) of linear raster position p on the reduced raster.
    function automatic logic exp_sync(input int p);
        int h, v, half;
        h = p % H;
        v = p / H;
        half = H / 2;
        if (v < 3) return !((h < BR) || (h >= half && h < half + BR));
        if (v < 5 || v >= V - 2) return !((h < EQ) || (h >= half && h < half + EQ));
        return !(h < HS);
    endfunction

    function automatic logic exp_act(input int p);
        int h, v;
        h = p % H;
        v = p / H;
        return (h >= AS) && (h < AS + AL) && (v >= VAS) && (v < VAS + VAL);
    endfunction

    // Reference model over a single linear frame index.
    int   m_p = 0;
    int   m_tick = 0;
    logic m_cs = 1'b1, m_vid = 1'b0, m_ls = 1'b0, m_fs = 1'b0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p <= 0; m_cs <= 1'b1; m_vid <= 1'b0; m_ls <= 1'b0; m_fs <= 1'b0;
        end else if (!en) begin
            m_p <= 0; m_cs <= 1'b1; m_vid <= 1'b0; m_ls <= 1'b0; m_fs <= 1'b0;
        end else if (ce) begin
            m_cs   <= exp_sync(m_p);
            m_vid  <= pix & exp_act(m_p) & exp_sync(m_p);
            m_p    <= (m_p + 1) % FRAME;
            m_ls   <= ((m_p + 1) % H) == 0;
            m_fs   <= (m_p == FRAME - 1);
            m_tick <= m_tick + 1;
        end else begin
            m_ls <= 1'b0;
            m_fs <= 1'b0;
        end
    end

    logic cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("hpos", hpos, m_p % H);
            chk("vpos", vpos, m_p / H);
            chk("active", active, exp_act(m_p));
            chk("csync", csync, m_cs);
            chk("video", video, m_vid);
            chk("line_start", line_start, m_ls);
            chk("frame_start", frame_start, m_fs);
        end
    end

    // Frame-level statistics between consecutive frame_start pulses.
    logic frm_chk = 1'b0;
    logic pix_all = 1'b0;
    int   exp_clk = 0;
    int   fs_n = 0;
    int   last_tick = 0, last_cyc = 0, ls_cnt = 0, vid_cnt = 0;

    always @(negedge clk) begin
        if (frm_chk && !rst) begin
            if (frame_start) begin
                if (fs_n > 0) begin
                    chk("fs_tick_gap", m_tick - last_tick, FRAME);
                    chk("fs_clk_gap", cyc - last_cyc, exp_clk);
                    chk("ls_per_frame", ls_cnt, V);
                    if (pix_all) chk("video_per_frame", vid_cnt, AL * VAL);
                end
                fs_n++;
                last_tick = m_tick;
                last_cyc  = cyc;
                ls_cnt    = 1;
                vid_cnt   = 0;
            end else if (line_start) begin
                ls_cnt++;
            end
            if (video) vid_cnt++;
        end
    end

    // Full-size raster observations; csync is attributed to the position it was decoded from.
    int d_n = 0, d_l10 = 0, d_l10_first = -1, d_l3 = 0, d_runs = 0;
    int d_run_len = 0, d_run_line = 0, d_vid = 0;
    always @(negedge clk) begin : dmon
        int pp, ph, pv;
        if (!rst && d_n < DN) begin
            pp = (int'(df_vpos) * 512 + int'(df_hpos) + DFRAME - 1) % DFRAME;
            ph = pp % 512;
            pv = pp / 512;
            d_n++;
            if (!df_csync) begin
                if (d_run_len == 0) d_run_line = pv;
                d_run_len++;
                if (pv == 10) begin
                    if (d_l10_first < 0) d_l10_first = ph;
                    d_l10++;
                end
                if (pv == 3) d_l3++;
            end else if (d_run_len > 0) begin
                if (d_run_line < 3) begin
                    d_runs++;
                    chk("broad_pulse_len", d_run_len, 218);
                end
                d_run_len = 0;
            end
            if (df_video) d_vid++;
        end
    end

    initial begin
        int k;
        logic found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hpos", hpos, 0);
        chk("rst_vpos", vpos, 0);
        chk("rst_csync", csync, 1);
        chk("rst_video", video, 0);
        chk("rst_line_start", line_start, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_def_csync", df_csync, 1);
        cmp_on = 1'b1;

        // Continuous ticks, white pixels.
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; en_def = 1'b1; ce = 1'b1; pix = 1'b1;
        pix_all = 1'b1; frm_chk = 1'b1; exp_clk = FRAME; fs_n = 0;
        repeat (6200) @(posedge clk);
        #1;
        chk("def_line10_low_ticks", d_l10, 38);
        chk("def_line10_first_low_h", d_l10_first, 0);
        chk("def_line3_low_ticks", d_l3, 38);
        chk("def_broad_pulses", d_runs, 6);
        chk("def_video_ones", d_vid, 0);

        // One tick in 25 clkp, random pixels.
        pix_all = 1'b0; exp_clk = FRAME * 25; fs_n = 0; k = 0;
        for (int i = 0; i < 45000 && fs_n < 2; i++) begin
            @(posedge clk); #1;
            ce  = (k % 25) == 0;
            pix = 1'($urandom);
            k++;
        end
        chk("slow_ce_frames_seen", fs_n >= 2, 1);

        // Random ticks, pixels and enable drops.
        frm_chk = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            ce  = ($urandom % 3) == 0;
            pix = 1'($urandom);
            en  = ($urandom % 150) != 0;
        end
        @(posedge clk); #1;
        en = 1'b1; ce = 1'b1;

        // Enable drop at line 10, h 20.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(posedge clk); #1;
            pix = 1'($urandom);
            if (hpos == 10'd20 && vpos == 9'd10) found = 1'b1;
        end
        chk("found_line10_h20", found, 1);
        en = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("en_low_csync", csync, 1);
            chk("en_low_video", video, 0);
            chk("en_low_hpos", hpos, 0);
            chk("en_low_pulse", line_start | frame_start, 0);
        end
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("restart_hpos", hpos, 1);
        chk("restart_vpos", vpos, 0);
        chk("restart_csync_low", csync, 0);

        // Asynchronous reset in the middle of a broad pulse.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(posedge clk); #1;
            if (hpos == 10'd5 && vpos == 9'd1) found = 1'b1;
        end
        chk("found_broad_pos", found, 1);
        chk("broad_csync_low", csync, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_csync", csync, 1);
        chk("async_rst_hpos", hpos, 0);
        chk("async_rst_vpos", vpos, 0);
        chk("async_rst_video", video, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("post_rst_hpos", hpos, 1);
        chk("post_rst_csync_low", csync, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
